// File: rtl/divider_ctrl_if.sv
// Config handshake and status bundle for the divided-clock/tick controller.
interface divider_ctrl_if #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned CNT_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_half_period;
    logic [CNT_W-1:0] cfg_pulses;
    logic             start;
    logic             stop;
    logic             div_out;
    logic             tick;
    logic             busy;
    logic             done;
    logic             pending;

    // Controller-facing side (drives config and commands).
    modport master (
        output cfg_valid, cfg_half_period, cfg_pulses, start, stop,
        input  cfg_ready, div_out, tick, busy, done, pending
    );

    // Divider-facing side (the controller itself).
    modport slave (
        input  cfg_valid, cfg_half_period, cfg_pulses, start, stop,
        output cfg_ready, div_out, tick, busy, done, pending
    );
endinterface

// File: rtl/divider_ctrl.sv
// Run-time controller for a programmable divided clock / tick generator.
// New config is staged in a shadow register while running and only takes
// effect on a half-period boundary, so div_out never glitches.
module divider_ctrl #(
    parameter int unsigned WIDTH     = 28,
    parameter int unsigned DEFAULT_N = 2147727,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    divider_ctrl_if.slave      bus
);

    // Half-period is stored as N-1 so the boundary test is a plain compare.
    localparam logic [WIDTH-1:0] DEFAULT_NM1 =
        (DEFAULT_N == 0) ? '0 : WIDTH'(DEFAULT_N - 1);
    localparam logic [CNT_W-1:0] PCNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] act_nm1, act_nm1_nxt;
    logic [CNT_W-1:0] act_pulses, act_pulses_nxt;
    logic [WIDTH-1:0] sh_nm1, sh_nm1_nxt;
    logic [CNT_W-1:0] sh_pulses, sh_pulses_nxt;
    logic [CNT_W-1:0] pcnt, pcnt_nxt;
    logic             div_q, div_nxt;
    logic             tick_q, tick_nxt;
    logic             done_q, done_nxt;
    logic             busy_q, busy_nxt;
    logic             pending_q, pending_nxt;
    logic             ready_q, ready_nxt;

    logic             accept;
    logic             at_bound;
    logic             finish_run;
    logic [WIDTH-1:0] cfg_nm1;
    logic [CNT_W-1:0] eff_pulses;

    assign bus.div_out   = div_q;
    assign bus.tick      = tick_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.pending   = pending_q;
    assign bus.cfg_ready = ready_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            act_nm1    <= DEFAULT_NM1;
            act_pulses <= '0;
            sh_nm1     <= '0;
            sh_pulses  <= '0;
            pcnt       <= '0;
            div_q      <= 1'b0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            pending_q  <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            act_nm1    <= act_nm1_nxt;
            act_pulses <= act_pulses_nxt;
            sh_nm1     <= sh_nm1_nxt;
            sh_pulses  <= sh_pulses_nxt;
            pcnt       <= pcnt_nxt;
            div_q      <= div_nxt;
            tick_q     <= tick_nxt;
            done_q     <= done_nxt;
            busy_q     <= busy_nxt;
            pending_q  <= pending_nxt;
            ready_q    <= ready_nxt;
        end
    end

    // Next-state, counter sequencing and config staging.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        act_nm1_nxt    = act_nm1;
        act_pulses_nxt = act_pulses;
        sh_nm1_nxt     = sh_nm1;
        sh_pulses_nxt  = sh_pulses;
        pcnt_nxt       = pcnt;
        div_nxt        = div_q;
        tick_nxt       = 1'b0;
        done_nxt       = 1'b0;
        pending_nxt    = pending_q;
        finish_run     = 1'b0;

        accept     = bus.cfg_valid & ready_q;
        // A half-period of 0 is treated as 1.
        cfg_nm1    = (bus.cfg_half_period == '0) ? '0
                                                 : bus.cfg_half_period - WIDTH'(1);
        at_bound   = (cnt == act_nm1);
        // Terminal count check sees the pulse target as it will be after a
        // shadow copy on this same boundary.
        eff_pulses = pending_q ? sh_pulses : act_pulses;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    act_nm1_nxt    = cfg_nm1;
                    act_pulses_nxt = bus.cfg_pulses;
                end
                if (bus.start) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                    pcnt_nxt  = '0;
                    div_nxt   = 1'b0;
                end
            end

            S_RUN: begin
                if (at_bound) begin
                    cnt_nxt  = '0;
                    div_nxt  = ~div_q;
                    tick_nxt = 1'b1;
                    if (pending_q) begin
                        act_nm1_nxt    = sh_nm1;
                        act_pulses_nxt = sh_pulses;
                        pending_nxt    = 1'b0;
                    end
                    if (!div_q) begin
                        if (pcnt != PCNT_MAX) begin
                            pcnt_nxt = pcnt + CNT_W'(1);
                        end
                    end else if ((eff_pulses != '0) && (pcnt == eff_pulses)) begin
                        finish_run = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + WIDTH'(1);
                end

                if (finish_run) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                    // Back in IDLE a fresh config goes straight to the active set.
                    if (accept) begin
                        act_nm1_nxt    = cfg_nm1;
                        act_pulses_nxt = bus.cfg_pulses;
                    end
                end else begin
                    if (accept) begin
                        sh_nm1_nxt    = cfg_nm1;
                        sh_pulses_nxt = bus.cfg_pulses;
                        pending_nxt   = 1'b1;
                    end
                    if (bus.stop) begin
                        state_nxt = S_STOPPING;
                    end
                end
            end

            S_STOPPING: begin
                if (!div_q) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else if (at_bound) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    div_nxt   = 1'b0;
                    tick_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + WIDTH'(1);
                end
                // Shadow held through the stop is applied as we reach IDLE.
                if ((state_nxt == S_IDLE) && pending_q) begin
                    act_nm1_nxt    = sh_nm1;
                    act_pulses_nxt = sh_pulses;
                    pending_nxt    = 1'b0;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                div_nxt   = 1'b0;
                cnt_nxt   = '0;
            end
        endcase

        busy_nxt  = (state_nxt != S_IDLE);
        ready_nxt = (state_nxt != S_STOPPING);
    end

endmodule
